// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready stalls, illegal-op detection and retire counter.
// Optional jal support is enabled by defining MIPS_MC_JAL_EN (adds the Link output).
module mips_multicycle_control #(
  parameter int unsigned ALUSEL_W = 4,
  parameter int unsigned RET_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                IRWE,
  output logic                PCWE,
  output logic                DMWE,
  output logic                RFWE,
  output logic                IorD,
  output logic                RFDSel,
  output logic                MtoRFSel,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALUSEL_W-1:0] ALUsel,
  output logic [3:0]          state,
`ifdef MIPS_MC_JAL_EN
  output logic                Link,
`endif
  output logic                instr_done,
  output logic                illegal,
  output logic [RET_W-1:0]    retired
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MIPS_MC_JAL_EN
  localparam logic [5:0] OpJal   = 6'b000011;
`endif

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  state_e           r_state, w_state_next;
  logic [RET_W-1:0] r_retired;
  logic [3:0]       w_alu_code;
  logic [3:0]       w_funct_alu;
  logic             w_funct_ok;
  logic             w_irwe, w_pcwe, w_dmwe, w_rfwe, w_done, w_illegal, w_link;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StFetch;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_done) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = AluAdd;
    unique case (funct)
      6'b100000: w_funct_alu = AluAdd;
      6'b100010: w_funct_alu = AluSub;
      6'b100100: w_funct_alu = AluAnd;
      6'b100101: w_funct_alu = AluOr;
      6'b101010: w_funct_alu = AluSlt;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_irwe       = 1'b0;
    w_pcwe       = 1'b0;
    w_dmwe       = 1'b0;
    w_rfwe       = 1'b0;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    w_link       = 1'b0;
    IorD         = 1'b0;
    RFDSel       = 1'b0;
    MtoRFSel     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    w_alu_code   = AluAdd;
    case (r_state)
      StFetch: begin
        ALUSrcB = 2'b01;
        w_irwe  = mem_ready;
        w_pcwe  = mem_ready;
        if (mem_ready) w_state_next = StDecode;
      end
      StDecode: begin
        ALUSrcB      = 2'b11;
        w_state_next = StFetch;
        case (opcode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype: begin
            if (w_funct_ok) w_state_next = StExec;
            else            w_illegal    = 1'b1;
          end
          OpBeq:  w_state_next = StBranch;
          OpAddi: w_state_next = StAddiEx;
          OpJ:    w_state_next = StJump;
`ifdef MIPS_MC_JAL_EN
          OpJal:  w_state_next = StJal;
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD = 1'b1;
        if (mem_ready) w_state_next = StMemWb;
      end
      StMemWb: begin
        w_rfwe       = 1'b1;
        MtoRFSel     = 1'b1;
        w_done       = 1'b1;
        w_state_next = StFetch;
      end
      StMemWr: begin
        IorD   = 1'b1;
        w_dmwe = mem_ready;
        w_done = mem_ready;
        if (mem_ready) w_state_next = StFetch;
      end
      StExec: begin
        ALUSrcA      = 1'b1;
        w_alu_code   = w_funct_alu;
        w_state_next = StAluWb;
      end
      StAluWb: begin
        w_rfwe       = 1'b1;
        RFDSel       = 1'b1;
        w_done       = 1'b1;
        w_state_next = StFetch;
      end
      StBranch: begin
        ALUSrcA      = 1'b1;
        w_alu_code   = AluSub;
        PCSrc        = 2'b01;
        w_pcwe       = zero;
        w_done       = 1'b1;
        w_state_next = StFetch;
      end
      StAddiEx: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = StAddiWb;
      end
      StAddiWb: begin
        w_rfwe       = 1'b1;
        w_done       = 1'b1;
        w_state_next = StFetch;
      end
      StJump: begin
        PCSrc        = 2'b10;
        w_pcwe       = 1'b1;
        w_done       = 1'b1;
        w_state_next = StFetch;
      end
`ifdef MIPS_MC_JAL_EN
      StJal: begin
        PCSrc        = 2'b10;
        w_pcwe       = 1'b1;
        w_rfwe       = 1'b1;
        w_link       = 1'b1;
        w_done       = 1'b1;
        w_state_next = StFetch;
      end
`endif
      default: w_state_next = StFetch;
    endcase
    // Reset gates every side effect so an aborted instruction writes nothing.
    if (!rst_n) begin
      w_irwe    = 1'b0;
      w_pcwe    = 1'b0;
      w_dmwe    = 1'b0;
      w_rfwe    = 1'b0;
      w_done    = 1'b0;
      w_illegal = 1'b0;
      w_link    = 1'b0;
    end
  end

  assign IRWE       = w_irwe;
  assign PCWE       = w_pcwe;
  assign DMWE       = w_dmwe;
  assign RFWE       = w_rfwe;
  assign instr_done = w_done;
  assign illegal    = w_illegal;
  assign ALUsel     = ALUSEL_W'(w_alu_code);
  assign state      = r_state;
  assign retired    = r_retired;
`ifdef MIPS_MC_JAL_EN
  assign Link = w_link;
`else
  logic w_unused;
  assign w_unused = w_link;
`endif

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction across fetch, decode, execute, memory and writeback cycles. It drives the shared-memory, PC, instruction-register, register-file and ALU controls of the multi-cycle datapath. Unlike the single-cycle decoder, it stalls on a memory ready handshake and flags illegal instructions. It keeps a retired-instruction counter and has a parametrised ALU select width.

## Interface
- ALUSEL_W, 4: ALUsel width (≥4); codes zero-extended.
- RET_W, 32: retired-instruction counter width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  instruction[31:26], valid from the IR after FETCH.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- IRWE, PCWE, DMWE, RFWE  out  1 each  IR, PC, data memory and register-file write enables.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- RFDSel  out  1  write register: 0 = rt, 1 = rd.
- MtoRFSel  out  1  write data: 0 = ALUOut, 1 = memory data.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUsel  out  ALUSEL_W  AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse on the final cycle of each legal instruction.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or R-type funct.
- retired  out  RET_W  count of completed instructions.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JAL=12. Codes 13–15 go to FETCH on the next edge.
- FETCH:
  - Drives IorD=0, ALUSrcA=0, ALUSrcB=01, ALUsel=ADD, PCSrc=00.
  - IRWE=PCWE=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE drives ALUSrcB=11, ALUsel=ADD (branch target into ALUOut). Next state by opcode:
  - lw (100011) or sw (101011) → MEMADR.
  - R-type (000000) → EXEC.
  - beq (000100) → BRANCH.
  - addi (001000) → ADDIEX.
  - j (000010) → JUMP.
  - Anything else → FETCH with illegal=1; the instruction executes as a NOP with PC already advanced.
  - R-type with funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} is also illegal.
- MEMADR drives ALUSrcA=1, ALUSrcB=10, ALUsel=ADD, then goes to MEMRD (lw) or MEMWR (sw).
- MEMRD drives IorD=1 and holds until mem_ready, then goes to MEMWB.
- MEMWB drives RFWE=1, RFDSel=0, MtoRFSel=1; instr_done; next FETCH.
- MEMWR drives IorD=1, DMWE=mem_ready; holds until mem_ready; instr_done in the completing cycle; next FETCH.
- EXEC drives ALUSrcA=1, ALUSrcB=00, ALUsel from funct.
- ALUWB drives RFWE=1, RFDSel=1, MtoRFSel=0; instr_done; next FETCH.
- BRANCH drives ALUSrcA=1, ALUSrcB=00, ALUsel=SUB, PCSrc=01, PCWE=zero; instr_done; next FETCH.
- ADDIEX drives ALUSrcA=1, ALUSrcB=10, ALUsel=ADD. ADDIWB drives RFWE=1, RFDSel=0; instr_done.
- JUMP drives PCSrc=10, PCWE=1; instr_done.
- Outputs not listed for a state are 0, with ALUsel=ADD.
- retired increments on every instr_done and wraps modulo 2^RET_W. Illegal instructions do not count.

## Timing
- Outputs are combinational from the state register and mem_ready/zero (Moore with gated enables).
- Reset: state=FETCH, retired=0. While rst_n=0, every write enable, instr_done and illegal are forced to 0; the other outputs hold their FETCH values.
- rst_n asserted mid-instruction aborts it immediately; no partial write may occur after assertion.
- Cycles with zero memory wait: beq/j 3, R-type/addi/sw 4, lw 5. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- An instruction's next FETCH begins the cycle after instr_done.

## Configuration
- MIPS_MC_JAL_EN:
  - Defined: jal (000011) goes DECODE → JAL.
  - JAL drives PCSrc=10, PCWE=1, RFWE=1 and the extra output Link=1 (write r31 with PC+4); instr_done; 3 cycles.
  - Undefined: the Link port is absent and jal is illegal.

## Test plan
- Reset mid-MEMRD with rst_n low 2 cycles → state=0, retired=0, no RFWE pulse; resumes FETCH.
- add (opcode 0, funct 100000), mem_ready=1 → ALUsel 0010 in EXEC; RFWE/RFDSel=1 at cycle 4; retired 0→1.
- lw with mem_ready low 3 cycles in MEMRD → 8 cycles total, single RFWE pulse with MtoRFSel=1.
- beq with zero=0, then zero=1 → PCWE=0, then 1, in BRANCH; both 3 cycles; retired +2.
- opcode 111111, then R-type funct 000001 → illegal pulses in DECODE, back to FETCH, retired unchanged.
- RET_W=4 with 17 legal instructions → retired wraps to 1; with MIPS_MC_JAL_EN, jal gives Link=RFWE=PCWE=1 on cycle 3.
